// File: rtl/triangle_wireframe.sv
// Bresenham wireframe rasterizer: walks V1->V2->V3->V1, one pixel per handshake.
// Define WIRE_CLIP_EN to suppress pixels outside the WIDTH x HEIGHT screen.
module triangle_wireframe #(
  parameter int FRAC_BITS = 8,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [1:0][15:0] V1,
  input  logic [1:0][15:0] V2,
  input  logic [1:0][15:0] V3,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      pix_x,
  output logic [15:0]      pix_y,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;

`ifdef WIRE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  localparam int HS = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic [16:0] HALF = (FRAC_BITS > 0) ? (17'd1 << HS) : 17'd0;
  localparam logic signed [15:0] XMAX = 16'(WIDTH - 1);
  localparam logic signed [15:0] YMAX = 16'(HEIGHT - 1);

  function automatic logic [15:0] to_int(input logic [15:0] v);
    logic signed [16:0] s;
    s = $signed({v[15], v}) + $signed(HALF);
    s = s >>> FRAC_BITS;
    return s[15:0];
  endfunction

  state_t state, state_n;

  logic [1:0][15:0] v1_q, v2_q, v3_q;
  logic [15:0] cur_x, cur_y, end_x, end_y;
  logic [16:0] dx, dy;
  logic [17:0] err;
  logic        sx_neg, sy_neg, one_shot;
  logic [1:0]  edge_idx;

  logic [15:0] c1x, c1y, c2x, c2y, c3x, c3y;
  logic [15:0] x0, y0, x1, y1;
  logic [16:0] dxs, dys, dx_abs, dy_neg;
  logic [17:0] err_ld, err_n;
  logic signed [18:0] e2;
  logic        step_x, step_y, degen;
  logic [15:0] nx, ny;
  logic        at_end, out_free, oob, off, adv, load_out;

  assign c1x = to_int(v1_q[0]);
  assign c1y = to_int(v1_q[1]);
  assign c2x = to_int(v2_q[0]);
  assign c2y = to_int(v2_q[1]);
  assign c3x = to_int(v3_q[0]);
  assign c3y = to_int(v3_q[1]);
  assign degen = (c1x == c2x) && (c1y == c2y)
              && (c1x == c3x) && (c1y == c3y);

  always_comb begin
    x0 = c1x; y0 = c1y; x1 = c2x; y1 = c2y;
    unique case (edge_idx)
      2'd1: begin x0 = c2x; y0 = c2y; x1 = c3x; y1 = c3y; end
      2'd2: begin x0 = c3x; y0 = c3y; x1 = c1x; y1 = c1y; end
      default: ;
    endcase
  end

  assign dxs    = {x1[15], x1} - {x0[15], x0};
  assign dys    = {y1[15], y1} - {y0[15], y0};
  assign dx_abs = dxs[16] ? (~dxs + 17'd1) : dxs;
  assign dy_neg = dys[16] ? dys : (~dys + 17'd1);
  assign err_ld = {1'b0, dx_abs} + {dy_neg[16], dy_neg};

  // Both axis decisions share the same doubled error term.
  assign e2     = {err, 1'b0};
  assign step_x = e2 >= $signed({{2{dy[16]}}, dy});
  assign step_y = e2 <= $signed({2'b00, dx});
  assign err_n  = err + (step_x ? {dy[16], dy} : 18'd0)
                      + (step_y ? {1'b0, dx} : 18'd0);
  assign nx = cur_x + (step_x ? (sx_neg ? 16'hFFFF : 16'h0001) : 16'h0000);
  assign ny = cur_y + (step_y ? (sy_neg ? 16'hFFFF : 16'h0001) : 16'h0000);

  assign oob = ($signed(cur_x) < 0) || ($signed(cur_x) > XMAX)
            || ($signed(cur_y) < 0) || ($signed(cur_y) > YMAX);
  assign off      = CLIP && oob;
  assign at_end   = (cur_x == end_x) && (cur_y == end_y) && !one_shot;
  assign out_free = !pix_valid || pix_ready;
  assign adv      = (state == STEP) && !at_end && (off || out_free);
  assign load_out = adv && !off;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = LOAD;
      end
      LOAD: state_n = STEP;
      STEP: begin
        if (at_end) begin
          if (edge_idx != 2'd2) state_n = LOAD;
          else if (out_free)    state_n = DONE;
        end else if (adv && !one_shot && nx == end_x && ny == end_y
                     && edge_idx != 2'd2) begin
          // Skip the idle compare cycle when the walk lands on the end point.
          state_n = LOAD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v1_q <= '0; v2_q <= '0; v3_q <= '0;
      cur_x <= '0; cur_y <= '0; end_x <= '0; end_y <= '0;
      dx <= '0; dy <= '0; err <= '0;
      sx_neg <= 1'b0; sy_neg <= 1'b0; one_shot <= 1'b0;
      edge_idx <= '0;
      pix_x <= '0; pix_y <= '0; pix_valid <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        v1_q <= V1; v2_q <= V2; v3_q <= V3;
        edge_idx <= 2'd0;
      end
      if (state == LOAD) begin
        cur_x <= x0; cur_y <= y0; end_x <= x1; end_y <= y1;
        dx <= dx_abs; dy <= dy_neg; err <= err_ld;
        sx_neg <= dxs[16]; sy_neg <= dys[16];
        one_shot <= (edge_idx == 2'd0) && degen;
      end
      if (adv) begin
        if (one_shot) begin
          one_shot <= 1'b0;
        end else begin
          cur_x <= nx; cur_y <= ny; err <= err_n;
        end
      end
      if (state == STEP && state_n == LOAD) edge_idx <= edge_idx + 2'd1;
      if (load_out) begin
        pix_x <= cur_x; pix_y <= cur_y; pix_valid <= 1'b1;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_triangle_wireframe.sv
// Directed bench for triangle_wireframe: pixel order, stalls, rounding,
// degenerate and off-screen triangles, asynchronous reset.
module tb_triangle_wireframe;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic [1:0][15:0] V1 = '0, V2 = '0, V3 = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      pix_x, pix_y;
  logic             pix_valid;
  logic             pix_ready = 1'b0;
  logic             busy, done;

  int checks = 0;
  int failures = 0;

  logic [31:0] got[$];
  int done_cnt, stall_err, first_cyc;
  bit timed_out;

  always #5 Clk = ~Clk;

  triangle_wireframe dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .V1(V1), .V2(V2), .V3(V3),
    .in_valid(in_valid), .in_ready(in_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .done(done)
  );

  task automatic submit(input logic [15:0] ax, ay, bx, by, cx, cy);
    @(negedge Clk);
    V1[0] = ax; V1[1] = ay;
    V2[0] = bx; V2[1] = by;
    V3[0] = cx; V3[1] = cy;
    in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    V1 = 32'h1234_5678; V2 = 32'h9ABC_DEF0; V3 = 32'h0F0F_F0F0;
  endtask

  // mode 0: ready always high; mode 1: ready toggles every cycle
  task automatic run_tri(input int mode);
    logic r;
    logic prev_stall;
    logic [15:0] px, py;
    int cyc;
    got.delete();
    done_cnt = 0; stall_err = 0; first_cyc = -1; timed_out = 0;
    prev_stall = 1'b0; px = '0; py = '0;
    cyc = 1;
    while (1) begin
      if (prev_stall && (pix_valid !== 1'b1 || pix_x !== px || pix_y !== py))
        stall_err++;
      r = (mode == 0) ? 1'b1 : cyc[0];
      pix_ready = r;
      if (pix_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
      if (pix_valid === 1'b1 && r) got.push_back({pix_x, pix_y});
      prev_stall = (pix_valid === 1'b1) && !r;
      px = pix_x; py = pix_y;
      if (done === 1'b1) done_cnt++;
      if (done_cnt > 0 && in_ready === 1'b1) break;
      if (cyc > 400) begin timed_out = 1; break; end
      @(negedge Clk);
      cyc++;
    end
    pix_ready = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      if (done === 1'b1) done_cnt++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, pix_valid, busy, done} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000", {in_ready, pix_valid, busy, done});
    end
    checks++;
    if ({pix_x, pix_y} !== 32'h0) begin
      failures++;
      $display("FAIL reset_pix got=%h exp=00000000", {pix_x, pix_y});
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got in_ready=%b busy=%b exp 1/0", in_ready, busy);
    end
  endtask

  task automatic check_nine(input string tag);
    logic [31:0] exp [9] = '{32'h0002_0002, 32'h0003_0002, 32'h0004_0002,
                             32'h0005_0002, 32'h0004_0003, 32'h0003_0004,
                             32'h0002_0005, 32'h0002_0004, 32'h0002_0003};
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL %s_timeout got=timeout exp=done", tag);
    end
    checks++;
    if (got.size() != 9) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=9", tag, got.size());
    end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL %s_pix[%0d] got=%h exp=%h", tag, i, got[i], exp[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL %s_done got=%0d exp=1", tag, done_cnt);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_idle got busy=%b in_ready=%b exp 0/1", tag, busy, in_ready);
    end
  endtask

  task automatic test_basic();
    submit(16'h0200, 16'h0200, 16'h0500, 16'h0200, 16'h0200, 16'h0500);
    run_tri(0);
    check_nine("basic");
    checks++;
    if (first_cyc != 3) begin
      failures++;
      $display("FAIL latency got=%0d exp=3", first_cyc);
    end
  endtask

  task automatic test_stall();
    submit(16'h0200, 16'h0200, 16'h0500, 16'h0200, 16'h0200, 16'h0500);
    run_tri(1);
    check_nine("stall");
    checks++;
    if (stall_err != 0) begin
      failures++;
      $display("FAIL stall_hold got=%0d exp=0", stall_err);
    end
  endtask

  task automatic test_single();
    submit(16'h0700, 16'h0300, 16'h0700, 16'h0300, 16'h0700, 16'h0300);
    run_tri(0);
    checks++;
    if (timed_out || got.size() != 1) begin
      failures++;
      $display("FAIL single_count got=%0d exp=1", got.size());
    end else begin
      checks++;
      if (got[0] !== 32'h0007_0003) begin
        failures++;
        $display("FAIL single_pix got=%h exp=00070003", got[0]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL single_done got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_rounding();
    submit(16'h0280, 16'h0000, 16'h027F, 16'h0400, 16'h0280, 16'h0000);
    run_tri(0);
    checks++;
    if (timed_out || got.size() != 8) begin
      failures++;
      $display("FAIL round_count got=%0d exp=8", got.size());
    end else begin
      checks++;
      if (got[0] !== 32'h0003_0000) begin
        failures++;
        $display("FAIL round_e0 got=%h exp=00030000", got[0]);
      end
      checks++;
      if (got[4] !== 32'h0002_0004) begin
        failures++;
        $display("FAIL round_e1 got=%h exp=00020004", got[4]);
      end
    end
  endtask

  task automatic test_offscreen();
`ifdef WIRE_CLIP_EN
    logic [31:0] exp [$] = '{32'h0000_0001, 32'h0001_0001, 32'h0000_0001};
`else
    logic [31:0] exp [$] = '{32'hFFFE_0001, 32'hFFFF_0001, 32'h0000_0001,
                             32'h0001_0001, 32'h0000_0001, 32'hFFFF_0001};
`endif
    submit(16'hFE00, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    run_tri(0);
    checks++;
    if (timed_out || got.size() != exp.size()) begin
      failures++;
      $display("FAIL offscr_count got=%0d exp=%0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL offscr_pix[%0d] got=%h exp=%h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    submit(16'h0200, 16'h0200, 16'h0500, 16'h0200, 16'h0200, 16'h0500);
    pix_ready = 1'b1;
    for (int c = 0; c < 50 && cnt < 2; c++) begin
      if (pix_valid === 1'b1) cnt++;
      if (cnt < 2) @(negedge Clk);
    end
    checks++;
    if (cnt != 2) begin
      failures++;
      $display("FAIL rstmid_wait got=%0d exp=2", cnt);
    end
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if ({pix_valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_async got=%b exp=000", {pix_valid, busy, done});
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ready got=%b exp=1", in_ready);
    end
    submit(16'h0200, 16'h0200, 16'h0500, 16'h0200, 16'h0200, 16'h0500);
    run_tri(0);
    check_nine("rstmid");
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_rounding();
    test_offscreen();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
